// File: rtl/idex_pkg.sv
// ID/EX skid-buffer shared types and constants.
// Optional operand forwarding is enabled by defining IDEX_FWD_EN.
package idex_pkg;

   localparam int XLEN_DEF = 32;
   localparam int OPW_DEF  = 4;

   localparam logic [4:0] REG_ZERO = 5'd0;

   typedef enum logic [OPW_DEF-1:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_SLL  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_SLT  = 4'd8,
      ALU_SLTU = 4'd9
   } alu_op_e;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_e;

   typedef struct packed {
      logic [XLEN_DEF-1:0] pc;
      logic [XLEN_DEF-1:0] imm;
      logic [XLEN_DEF-1:0] a;
      logic [XLEN_DEF-1:0] b;
      logic [4:0]          rs1;
      logic [4:0]          rs2;
      logic [4:0]          rd;
      logic [OPW_DEF-1:0]  alu_op;
      logic                reg_write;
      logic                mem_read;
      logic                mem_write;
   } idex_entry_t;

endpackage

// File: rtl/idex_bypass.sv
// Operand select for one source operand: capture plus held-entry update.
// Write-back forwarding is compiled in only when IDEX_FWD_EN is defined.
module idex_bypass
   import idex_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
) (
   input  logic [4:0]      cap_rs,
   input  logic [XLEN-1:0] cap_val,
   input  logic [4:0]      main_rs,
   input  logic [XLEN-1:0] main_val,
   input  logic [4:0]      skid_rs,
   input  logic [XLEN-1:0] skid_val,
   input  logic            wb_en,
   input  logic [4:0]      wb_rd,
   input  logic [XLEN-1:0] wb_data,
   output logic [XLEN-1:0] cap_out,
   output logic [XLEN-1:0] main_out,
   output logic [XLEN-1:0] skid_out
);

`ifdef IDEX_FWD_EN
   logic wb_live;

   assign wb_live = wb_en && (wb_rd != REG_ZERO);

   // x0 reads as zero; otherwise a matching write-back wins over stale data
   always_comb begin
      cap_out  = cap_val;
      main_out = main_val;
      skid_out = skid_val;
      if (cap_rs == REG_ZERO)
         cap_out = '0;
      else if (wb_live && (wb_rd == cap_rs))
         cap_out = wb_data;
      if (wb_live && (wb_rd == main_rs))
         main_out = wb_data;
      if (wb_live && (wb_rd == skid_rs))
         skid_out = wb_data;
   end
`else
   logic unused_fwd;

   assign unused_fwd = ^{main_rs, skid_rs, wb_en, wb_rd, wb_data};

   // without forwarding only the x0 forcing remains
   always_comb begin
      cap_out  = (cap_rs == REG_ZERO) ? '0 : cap_val;
      main_out = main_val;
      skid_out = skid_val;
   end
`endif

endmodule

// File: rtl/idex_stage.sv
// ID/EX pipeline register as a 2-entry skid buffer (main + skid).
// Define IDEX_FWD_EN to enable write-back forwarding into held operands.
module idex_stage
   import idex_pkg::*;
#(
   parameter int XLEN = XLEN_DEF,
   parameter int OPW  = OPW_DEF
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] in_pc,
   input  logic [XLEN-1:0] in_imm,
   input  logic [4:0]      rs1,
   input  logic [4:0]      rs2,
   input  logic [4:0]      rd,
   input  logic [XLEN-1:0] rs1_value,
   input  logic [XLEN-1:0] rs2_value,
   input  logic [OPW-1:0]  in_alu_op,
   input  logic            in_RegWrite,
   input  logic            in_MemRead,
   input  logic            in_MemWrite,
   input  logic            wb_RegWrite,
   input  logic [4:0]      wb_rd,
   input  logic [XLEN-1:0] wb_data,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [XLEN-1:0] out_imm,
   output logic [XLEN-1:0] out_a,
   output logic [XLEN-1:0] out_b,
   output logic [4:0]      out_rd,
   output logic [OPW-1:0]  out_alu_op,
   output logic            out_RegWrite,
   output logic            out_MemRead,
   output logic            out_MemWrite
);

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] imm;
      logic [XLEN-1:0] a;
      logic [XLEN-1:0] b;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic [OPW-1:0]  alu_op;
      logic            reg_write;
      logic            mem_read;
      logic            mem_write;
   } entry_t;

   state_e state;
   state_e state_n;

   entry_t main_q;
   entry_t skid_q;
   entry_t main_n;
   entry_t skid_n;
   entry_t cap_e;
   entry_t main_u;
   entry_t skid_u;

   logic [XLEN-1:0] cap_a;
   logic [XLEN-1:0] cap_b;
   logic [XLEN-1:0] main_a;
   logic [XLEN-1:0] main_b;
   logic [XLEN-1:0] skid_a;
   logic [XLEN-1:0] skid_b;

   logic take_in;
   logic take_out;

   assign in_ready  = (state != ST_FULL);
   assign out_valid = (state != ST_EMPTY);
   assign take_in   = in_valid && in_ready;
   assign take_out  = out_valid && out_ready;

   idex_bypass #(.XLEN(XLEN)) u_byp_a (
      .cap_rs   (rs1),
      .cap_val  (rs1_value),
      .main_rs  (main_q.rs1),
      .main_val (main_q.a),
      .skid_rs  (skid_q.rs1),
      .skid_val (skid_q.a),
      .wb_en    (wb_RegWrite),
      .wb_rd    (wb_rd),
      .wb_data  (wb_data),
      .cap_out  (cap_a),
      .main_out (main_a),
      .skid_out (skid_a)
   );

   idex_bypass #(.XLEN(XLEN)) u_byp_b (
      .cap_rs   (rs2),
      .cap_val  (rs2_value),
      .main_rs  (main_q.rs2),
      .main_val (main_q.b),
      .skid_rs  (skid_q.rs2),
      .skid_val (skid_q.b),
      .wb_en    (wb_RegWrite),
      .wb_rd    (wb_rd),
      .wb_data  (wb_data),
      .cap_out  (cap_b),
      .main_out (main_b),
      .skid_out (skid_b)
   );

   // incoming entry and write-back-refreshed copies of the held entries
   always_comb begin
      cap_e.pc        = in_pc;
      cap_e.imm       = in_imm;
      cap_e.a         = cap_a;
      cap_e.b         = cap_b;
      cap_e.rs1       = rs1;
      cap_e.rs2       = rs2;
      cap_e.rd        = rd;
      cap_e.alu_op    = in_alu_op;
      cap_e.reg_write = in_RegWrite;
      cap_e.mem_read  = in_MemRead;
      cap_e.mem_write = in_MemWrite;
      main_u          = main_q;
      main_u.a        = main_a;
      main_u.b        = main_b;
      skid_u          = skid_q;
      skid_u.a        = skid_a;
      skid_u.b        = skid_b;
   end

   // occupancy FSM: next state and entry moves; flush beats any transfer
   always_comb begin
      state_n = state;
      main_n  = main_u;
      skid_n  = skid_u;
      if (flush) begin
         state_n = ST_EMPTY;
      end else begin
         unique case (state)
            ST_EMPTY: begin
               if (take_in) begin
                  state_n = ST_ONE;
                  main_n  = cap_e;
               end
            end
            ST_ONE: begin
               unique case (1'b1)
                  (take_in && take_out): begin
                     main_n = cap_e;
                  end
                  (take_in && !take_out): begin
                     state_n = ST_FULL;
                     skid_n  = cap_e;
                  end
                  (!take_in && take_out): begin
                     state_n = ST_EMPTY;
                  end
                  default: begin
                  end
               endcase
            end
            ST_FULL: begin
               if (take_out) begin
                  state_n = ST_ONE;
                  main_n  = skid_u;
               end
            end
            default: begin
               state_n = ST_EMPTY;
            end
         endcase
      end
   end

   // state and payload registers, cleared immediately by reset
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state  <= ST_EMPTY;
         main_q <= '0;
         skid_q <= '0;
      end else begin
         state  <= state_n;
         main_q <= main_n;
         skid_q <= skid_n;
      end
   end

   assign out_pc       = main_q.pc;
   assign out_imm      = main_q.imm;
   assign out_a        = main_q.a;
   assign out_b        = main_q.b;
   assign out_rd       = main_q.rd;
   assign out_alu_op   = main_q.alu_op;
   assign out_RegWrite = main_q.reg_write;
   assign out_MemRead  = main_q.mem_read;
   assign out_MemWrite = main_q.mem_write;

endmodule

// File: tb/tb_idex_stage.sv
// Directed self-checking bench for idex_stage.
// Expected operand values follow IDEX_FWD_EN when it is defined.
module tb_idex_stage;
   import idex_pkg::*;

   localparam int XL = 32;
   localparam int OW = 4;

`ifdef IDEX_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic          CLK;
   logic          RST;
   logic          in_valid;
   logic          in_ready;
   logic [XL-1:0] in_pc;
   logic [XL-1:0] in_imm;
   logic [4:0]    rs1;
   logic [4:0]    rs2;
   logic [4:0]    rd;
   logic [XL-1:0] rs1_value;
   logic [XL-1:0] rs2_value;
   logic [OW-1:0] in_alu_op;
   logic          in_RegWrite;
   logic          in_MemRead;
   logic          in_MemWrite;
   logic          wb_RegWrite;
   logic [4:0]    wb_rd;
   logic [XL-1:0] wb_data;
   logic          flush;
   logic          out_valid;
   logic          out_ready;
   logic [XL-1:0] out_pc;
   logic [XL-1:0] out_imm;
   logic [XL-1:0] out_a;
   logic [XL-1:0] out_b;
   logic [4:0]    out_rd;
   logic [OW-1:0] out_alu_op;
   logic          out_RegWrite;
   logic          out_MemRead;
   logic          out_MemWrite;

   int n_chk;
   int n_fail;

   idex_stage #(.XLEN(XL), .OPW(OW)) dut (
      .CLK          (CLK),
      .RST          (RST),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_pc        (in_pc),
      .in_imm       (in_imm),
      .rs1          (rs1),
      .rs2          (rs2),
      .rd           (rd),
      .rs1_value    (rs1_value),
      .rs2_value    (rs2_value),
      .in_alu_op    (in_alu_op),
      .in_RegWrite  (in_RegWrite),
      .in_MemRead   (in_MemRead),
      .in_MemWrite  (in_MemWrite),
      .wb_RegWrite  (wb_RegWrite),
      .wb_rd        (wb_rd),
      .wb_data      (wb_data),
      .flush        (flush),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_pc       (out_pc),
      .out_imm      (out_imm),
      .out_a        (out_a),
      .out_b        (out_b),
      .out_rd       (out_rd),
      .out_alu_op   (out_alu_op),
      .out_RegWrite (out_RegWrite),
      .out_MemRead  (out_MemRead),
      .out_MemWrite (out_MemWrite)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle();
      in_valid    = 1'b0;
      in_pc       = '0;
      in_imm      = '0;
      rs1         = 5'd1;
      rs2         = 5'd1;
      rd          = 5'd0;
      rs1_value   = '0;
      rs2_value   = '0;
      in_alu_op   = ALU_ADD;
      in_RegWrite = 1'b0;
      in_MemRead  = 1'b0;
      in_MemWrite = 1'b0;
      wb_RegWrite = 1'b0;
      wb_rd       = 5'd0;
      wb_data     = '0;
      flush       = 1'b0;
      out_ready   = 1'b1;
   endtask

   task automatic test_reset();
      RST = 1'b1;
      idle();
      #12;
      n_chk++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_valid: got %b exp 0", out_valid);
      end
      n_chk++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_ready: got %b exp 1", in_ready);
      end
      n_chk++;
      if (out_pc !== 32'h0 || out_a !== 32'h0) begin
         n_fail++;
         $display("FAIL rst_payload: pc %h a %h exp 0", out_pc, out_a);
      end
      RST = 1'b0;
      tick();
   endtask

   task automatic test_stream();
      logic [XL-1:0] exp_pc;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_valid    = 1'b1;
         in_pc       = 32'(i * 4);
         in_imm      = 32'(16'h100 + i);
         rs1         = 5'd1;
         rs1_value   = 32'(8'hA0 + i);
         rd          = 5'(i + 1);
         in_alu_op   = ALU_SUB;
         in_RegWrite = 1'b1;
         tick();
         exp_pc = 32'(i * 4);
         n_chk++;
         if (out_valid !== 1'b1 || out_pc !== exp_pc) begin
            n_fail++;
            $display("FAIL stream_pc%0d: v %b pc %h exp 1 %h",
                     i, out_valid, out_pc, exp_pc);
         end
         n_chk++;
         if (out_a !== 32'(8'hA0 + i) || out_rd !== 5'(i + 1)) begin
            n_fail++;
            $display("FAIL stream_pay%0d: a %h rd %0d exp %h %0d",
                     i, out_a, out_rd, 32'(8'hA0 + i), i + 1);
         end
      end
      n_chk++;
      if (out_alu_op !== ALU_SUB || out_RegWrite !== 1'b1) begin
         n_fail++;
         $display("FAIL stream_ctl: op %h rw %b exp %h 1",
                  out_alu_op, out_RegWrite, ALU_SUB);
      end
      idle();
      tick();
      n_chk++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL stream_drain: got %b exp 0", out_valid);
      end
   endtask

   task automatic test_backpressure();
      idle();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_pc     = 32'h100;
      tick();
      n_chk++;
      if (in_ready !== 1'b1 || out_pc !== 32'h100) begin
         n_fail++;
         $display("FAIL bp_one: rdy %b pc %h exp 1 100", in_ready, out_pc);
      end
      in_pc = 32'h104;
      tick();
      n_chk++;
      if (in_ready !== 1'b0 || out_pc !== 32'h100) begin
         n_fail++;
         $display("FAIL bp_full: rdy %b pc %h exp 0 100", in_ready, out_pc);
      end
      in_pc = 32'h108;
      tick();
      n_chk++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_hold: rdy %b v %b exp 0 1", in_ready, out_valid);
      end
      out_ready = 1'b1;
      tick();
      n_chk++;
      if (out_pc !== 32'h104 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_rel1: pc %h rdy %b exp 104 1", out_pc, in_ready);
      end
      tick();
      n_chk++;
      if (out_pc !== 32'h108 || out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_rel2: pc %h v %b exp 108 1", out_pc, out_valid);
      end
      in_valid = 1'b0;
      tick();
      n_chk++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_drain: got %b exp 0", out_valid);
      end
   endtask

   task automatic test_bypass();
      logic [XL-1:0] exp_a;
      idle();
      exp_a       = FWD ? 32'h99 : 32'h32;
      in_valid    = 1'b1;
      in_pc       = 32'h180;
      rs1         = 5'd3;
      rs1_value   = 32'h32;
      rs2         = 5'd7;
      rs2_value   = 32'h1234;
      wb_RegWrite = 1'b1;
      wb_rd       = 5'd3;
      wb_data     = 32'h99;
      tick();
      n_chk++;
      if (out_a !== exp_a) begin
         n_fail++;
         $display("FAIL byp_a: got %h exp %h", out_a, exp_a);
      end
      n_chk++;
      if (out_b !== 32'h1234) begin
         n_fail++;
         $display("FAIL byp_b_nomatch: got %h exp 1234", out_b);
      end
      in_valid    = 1'b1;
      in_pc       = 32'h184;
      rs1         = 5'd0;
      rs1_value   = 32'h55;
      wb_rd       = 5'd0;
      wb_data     = 32'h77;
      tick();
      n_chk++;
      if (out_a !== 32'h0 || out_pc !== 32'h184) begin
         n_fail++;
         $display("FAIL byp_x0: a %h pc %h exp 0 184", out_a, out_pc);
      end
      idle();
      tick();
   endtask

   task automatic test_held_update();
      logic [XL-1:0] exp_a;
      logic [XL-1:0] exp_b;
      idle();
      exp_a     = FWD ? 32'h20 : 32'h66;
      exp_b     = FWD ? 32'h10 : 32'h0B;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_pc     = 32'h200;
      rs1       = 5'd1;
      rs1_value = 32'h1;
      rs2       = 5'd1;
      rs2_value = 32'hAA;
      tick();
      in_pc     = 32'h204;
      rs1       = 5'd6;
      rs1_value = 32'h66;
      rs2       = 5'd5;
      rs2_value = 32'h0B;
      tick();
      in_valid    = 1'b0;
      wb_RegWrite = 1'b1;
      wb_rd       = 5'd5;
      wb_data     = 32'h10;
      tick();
      n_chk++;
      if (out_pc !== 32'h200 || out_b !== 32'hAA) begin
         n_fail++;
         $display("FAIL held_main: pc %h b %h exp 200 aa", out_pc, out_b);
      end
      wb_rd     = 5'd6;
      wb_data   = 32'h20;
      out_ready = 1'b1;
      tick();
      n_chk++;
      if (out_pc !== 32'h204 || out_b !== exp_b) begin
         n_fail++;
         $display("FAIL held_b: pc %h b %h exp 204 %h", out_pc, out_b, exp_b);
      end
      n_chk++;
      if (out_a !== exp_a) begin
         n_fail++;
         $display("FAIL held_move_a: got %h exp %h", out_a, exp_a);
      end
      wb_RegWrite = 1'b0;
      tick();
      n_chk++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL held_drain: got %b exp 0", out_valid);
      end
   endtask

   task automatic test_flush();
      idle();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_pc     = 32'h300;
      tick();
      in_pc = 32'h304;
      tick();
      flush     = 1'b1;
      in_pc     = 32'h308;
      out_ready = 1'b1;
      tick();
      n_chk++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL flush_empty: v %b rdy %b exp 0 1", out_valid, in_ready);
      end
      flush    = 1'b0;
      in_valid = 1'b0;
      tick();
      n_chk++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_noleak: v %b pc %h exp 0", out_valid, out_pc);
      end
      in_valid = 1'b1;
      in_pc    = 32'h30C;
      tick();
      n_chk++;
      if (out_valid !== 1'b1 || out_pc !== 32'h30C) begin
         n_fail++;
         $display("FAIL flush_next: v %b pc %h exp 1 30c", out_valid, out_pc);
      end
      in_valid = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid();
      idle();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_pc     = 32'h400;
      rs1       = 5'd2;
      rs1_value = 32'h5A;
      tick();
      in_pc = 32'h404;
      tick();
      n_chk++;
      if (out_a !== 32'h5A || in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL rmid_pre: a %h rdy %b exp 5a 0", out_a, in_ready);
      end
      RST = 1'b1;
      #2;
      n_chk++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL rmid_ctl: v %b rdy %b exp 0 1", out_valid, in_ready);
      end
      n_chk++;
      if (out_a !== 32'h0 || out_pc !== 32'h0) begin
         n_fail++;
         $display("FAIL rmid_pay: a %h pc %h exp 0 0", out_a, out_pc);
      end
      #2;
      RST       = 1'b0;
      in_pc     = 32'h500;
      rs1_value = 32'h77;
      out_ready = 1'b1;
      tick();
      n_chk++;
      if (out_valid !== 1'b1 || out_pc !== 32'h500 || out_a !== 32'h77) begin
         n_fail++;
         $display("FAIL rmid_post: v %b pc %h a %h exp 1 500 77",
                  out_valid, out_pc, out_a);
      end
      in_valid = 1'b0;
      tick();
      n_chk++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL rmid_drain: v %b pc %h exp 0", out_valid, out_pc);
      end
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      test_reset();
      test_stream();
      test_backpressure();
      test_bypass();
      test_held_update();
      test_flush();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
